// File: rtl/synth_pkg.sv
// -----------------------------------------------------------------------------
// synth_pkg
// Shared definitions for the envelope / VCA slice.
//   env_state_t : envelope phase encoding (also driven out on EnvState)
//   ENV_MAX     : all-ones envelope ceiling, truncated to ENV_DEPTH by users
//   is_stepping : phases in which the rate counter paces the level
// -----------------------------------------------------------------------------
package synth_pkg;

  typedef enum logic [2:0] {
    ENV_IDLE    = 3'd0,
    ENV_ATTACK  = 3'd1,
    ENV_DECAY   = 3'd2,
    ENV_SUSTAIN = 3'd3,
    ENV_RELEASE = 3'd4
  } env_state_t;

  // Wide all-ones constant; each user slices off its own envelope width.
  localparam logic [31:0] ENV_MAX = 32'hFFFF_FFFF;

  // True for the phases whose level moves at a programmable rate.
  function automatic logic is_stepping(input env_state_t s);
    return (s == ENV_ATTACK) || (s == ENV_DECAY) || (s == ENV_RELEASE);
  endfunction

endpackage

// File: rtl/env_rate_counter.sv
// -----------------------------------------------------------------------------
// env_rate_counter
// Divides the clock by (Rate + 1) to pace envelope level steps.
//   Clock : rising-edge clock
//   Reset : asynchronous active-high reset, counter to 0
//   Clear : restart the count at 0 (phase entry / non-stepping phases)
//   Rate  : clocks per step minus 1
//   Step  : high for the one clock in which the count matches Rate
// Step is decoded from the current count so the level moves in the same
// clock the counter wraps to 0.
// -----------------------------------------------------------------------------
module env_rate_counter #(
  parameter int ENV_DEPTH = 8
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Clear,
  input  logic [ENV_DEPTH-1:0] Rate,
  output logic                 Step
);

  localparam logic [ENV_DEPTH-1:0] CNT_ONE = {{(ENV_DEPTH-1){1'b0}}, 1'b1};

  logic [ENV_DEPTH-1:0] rate_cnt;
  logic                 at_rate;

  // Compare against the live rate; suppressed while being cleared.
  always_comb begin
    at_rate = (rate_cnt == Rate);
    Step    = at_rate & ~Clear;
  end

  // Count register: clear wins, otherwise wrap at Rate or increment.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rate_cnt <= '0;
    end else if (Clear || at_rate) begin
      rate_cnt <= '0;
    end else begin
      rate_cnt <= rate_cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/envelope_vca.sv
// -----------------------------------------------------------------------------
// envelope_vca
// ADSR envelope generator driving a multiplying VCA on an unsigned sample.
//   Clock    : rising-edge clock
//   Reset    : asynchronous active-high reset (aborts any note, no tail)
//   Gate     : note held while high; a 0->1 transition retriggers Attack
//   Attack   : clocks per rising level step, minus 1
//   Decay    : clocks per falling level step toward Sustain, minus 1
//   Sustain  : held level, tracked live while in Sustain
//   Release  : clocks per falling level step after gate off, minus 1
//   Waveform : unsigned input sample
//   Out      : registered upper WAVE_DEPTH bits of Waveform * Level
//   Level    : current envelope level
//   EnvState : Idle=0 Attack=1 Decay=2 Sustain=3 Release=4
// Build option: define ENV_LEGATO_RETRIGGER_EN to make a retrigger keep the
// current level (Attack continues upward from it); by default a retrigger
// restarts the level at 0.
// -----------------------------------------------------------------------------
module envelope_vca
  import synth_pkg::*;
#(
  parameter int WAVE_DEPTH = 8,
  parameter int ENV_DEPTH  = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Gate,
  input  logic [ENV_DEPTH-1:0]  Attack,
  input  logic [ENV_DEPTH-1:0]  Decay,
  input  logic [ENV_DEPTH-1:0]  Release,
  input  logic [ENV_DEPTH-1:0]  Sustain,
  input  logic [WAVE_DEPTH-1:0] Waveform,
  output logic [WAVE_DEPTH-1:0] Out,
  output logic [ENV_DEPTH-1:0]  Level,
  output logic [2:0]            EnvState
);

  localparam logic [ENV_DEPTH-1:0] LEVEL_MAX = ENV_MAX[ENV_DEPTH-1:0];
  localparam logic [ENV_DEPTH-1:0] LEVEL_ONE = {{(ENV_DEPTH-1){1'b0}}, 1'b1};
  localparam int                   PROD_W    = WAVE_DEPTH + ENV_DEPTH;

  env_state_t           state;
  env_state_t           state_next;
  logic [ENV_DEPTH-1:0] level_next;
  logic                 gate_prev;
  logic                 rise;
  logic                 step;
  logic                 clear_cnt;
  logic [ENV_DEPTH-1:0] rate_sel;
  logic [PROD_W-1:0]    prod;

  assign rise     = Gate & ~gate_prev;
  assign EnvState = state;

  // Pick the pacing rate for the phase the envelope is currently in.
  always_comb begin
    rate_sel = '0;
    case (state)
      ENV_ATTACK:  rate_sel = Attack;
      ENV_DECAY:   rate_sel = Decay;
      ENV_RELEASE: rate_sel = Release;
      default:     rate_sel = '0;
    endcase
  end

  // Restart the count on retrigger, on every phase change, and park it
  // at 0 in phases that do not step.
  always_comb begin
    clear_cnt = rise | (state_next != state) | ~is_stepping(state);
  end

  env_rate_counter #(
    .ENV_DEPTH (ENV_DEPTH)
  ) u_rate (
    .Clock (Clock),
    .Reset (Reset),
    .Clear (clear_cnt),
    .Rate  (rate_sel),
    .Step  (step)
  );

  // Envelope phase and level transitions; a retrigger overrides everything.
  always_comb begin
    state_next = state;
    level_next = Level;
    if (rise) begin
      state_next = ENV_ATTACK;
`ifdef ENV_LEGATO_RETRIGGER_EN
      level_next = Level;
`else
      level_next = '0;
`endif
    end else begin
      case (state)
        ENV_IDLE: begin
          level_next = '0;
        end
        ENV_ATTACK: begin
          if (!Gate) begin
            state_next = ENV_RELEASE;
          end else if (Level == LEVEL_MAX) begin
            // Saturate: hand over to Decay instead of wrapping.
            state_next = ENV_DECAY;
          end else if (step) begin
            level_next = Level + LEVEL_ONE;
          end else begin
            level_next = Level;
          end
        end
        ENV_DECAY: begin
          if (!Gate) begin
            state_next = ENV_RELEASE;
          end else if (Level <= Sustain) begin
            state_next = ENV_SUSTAIN;
          end else if (step) begin
            level_next = Level - LEVEL_ONE;
          end else begin
            level_next = Level;
          end
        end
        ENV_SUSTAIN: begin
          if (!Gate) begin
            state_next = ENV_RELEASE;
          end else begin
            level_next = Sustain;
          end
        end
        ENV_RELEASE: begin
          if (Level == '0) begin
            state_next = ENV_IDLE;
            level_next = '0;
          end else if (step) begin
            level_next = Level - LEVEL_ONE;
          end else begin
            level_next = Level;
          end
        end
        default: begin
          state_next = ENV_IDLE;
          level_next = '0;
        end
      endcase
    end
  end

  // Phase, level and gate history registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= ENV_IDLE;
      Level     <= '0;
      gate_prev <= 1'b0;
    end else begin
      state     <= state_next;
      Level     <= level_next;
      gate_prev <= Gate;
    end
  end

  // Full-width product of the sample and the registered level.
  always_comb begin
    prod = {{ENV_DEPTH{1'b0}}, Waveform} * {{WAVE_DEPTH{1'b0}}, Level};
  end

  // VCA output: keep the top WAVE_DEPTH bits (full scale lands one LSB short).
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      Out <= '0;
    end else begin
      Out <= WAVE_DEPTH'(prod >> ENV_DEPTH);
    end
  end

endmodule

// File: tb/tb_envelope_vca.sv
// -----------------------------------------------------------------------------
// tb_envelope_vca
// Directed bench for envelope_vca (8-bit sample, 8-bit envelope).
// -----------------------------------------------------------------------------
module tb_envelope_vca;

  logic       Clock;
  logic       Reset;
  logic       Gate;
  logic [7:0] Attack;
  logic [7:0] Decay;
  logic [7:0] Release;
  logic [7:0] Sustain;
  logic [7:0] Waveform;
  logic [7:0] Out;
  logic [7:0] Level;
  logic [2:0] EnvState;

  int checks;
  int errors;

  envelope_vca #(
    .WAVE_DEPTH (8),
    .ENV_DEPTH  (8)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Gate     (Gate),
    .Attack   (Attack),
    .Decay    (Decay),
    .Release  (Release),
    .Sustain  (Sustain),
    .Waveform (Waveform),
    .Out      (Out),
    .Level    (Level),
    .EnvState (EnvState)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Gate  = 1'b0;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  // Stimulus only: gate on with fast rates and sit in Sustain at 128.
  task automatic run_to_sustain();
    do_reset();
    Attack  = 8'd0;
    Decay   = 8'd0;
    Release = 8'd0;
    Sustain = 8'd128;
    Gate    = 1'b1;
    repeat (385) tick();
  endtask

  task automatic test_reset();
    Reset = 1'b1; Gate = 1'b0; Attack = 8'd0; Decay = 8'd0;
    Release = 8'd0; Sustain = 8'd0; Waveform = 8'd0;
    #2;
    checks++;
    if (EnvState !== 3'd0 || Level !== 8'd0 || Out !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: state=%0d level=%0d out=%0d, need 0/0/0", EnvState, Level, Out);
    end
    tick();
    Reset = 1'b0;
    tick();
    checks++;
    if (EnvState !== 3'd0 || Level !== 8'd0) begin
      errors++;
      $display("FAIL idle_after_reset: state=%0d level=%0d, need 0/0", EnvState, Level);
    end
  endtask

  task automatic test_attack_decay_sustain();
    do_reset();
    Attack = 8'd0; Decay = 8'd0; Release = 8'd0; Sustain = 8'd128;
    Gate = 1'b1;
    tick();
    checks++;
    if (EnvState !== 3'd1 || Level !== 8'd0) begin
      errors++;
      $display("FAIL ads_enter_attack: state=%0d level=%0d, need 1/0", EnvState, Level);
    end
    for (int t = 1; t <= 255; t++) begin
      tick();
      checks++;
      if (EnvState !== 3'd1 || Level !== 8'(t)) begin
        errors++;
        $display("FAIL ads_attack_ramp t=%0d: state=%0d level=%0d, need 1/%0d", t, EnvState, Level, t);
      end
    end
    tick();
    checks++;
    if (EnvState !== 3'd2 || Level !== 8'd255) begin
      errors++;
      $display("FAIL ads_enter_decay: state=%0d level=%0d, need 2/255", EnvState, Level);
    end
    for (int j = 1; j <= 127; j++) begin
      tick();
      checks++;
      if (EnvState !== 3'd2 || Level !== 8'(255 - j)) begin
        errors++;
        $display("FAIL ads_decay_ramp j=%0d: state=%0d level=%0d, need 2/%0d", j, EnvState, Level, 255 - j);
      end
    end
    tick();
    checks++;
    if (EnvState !== 3'd3 || Level !== 8'd128) begin
      errors++;
      $display("FAIL ads_enter_sustain: state=%0d level=%0d, need 3/128", EnvState, Level);
    end
    Sustain = 8'd140;
    tick();
    checks++;
    if (EnvState !== 3'd3 || Level !== 8'd140) begin
      errors++;
      $display("FAIL ads_sustain_track: state=%0d level=%0d, need 3/140", EnvState, Level);
    end
  endtask

  task automatic test_attack_rate();
    do_reset();
    Attack = 8'd3; Decay = 8'd0; Release = 8'd0; Sustain = 8'd0;
    Gate = 1'b1;
    tick();
    for (int t = 1; t <= 12; t++) begin
      tick();
      checks++;
      if (EnvState !== 3'd1 || Level !== 8'(t / 4)) begin
        errors++;
        $display("FAIL attack_rate3 t=%0d: state=%0d level=%0d, need 1/%0d", t, EnvState, Level, t / 4);
      end
    end
  endtask

  task automatic test_release();
    do_reset();
    Attack = 8'd0; Decay = 8'd0; Release = 8'd1; Sustain = 8'd0;
    Gate = 1'b1;
    repeat (101) tick();
    checks++;
    if (EnvState !== 3'd1 || Level !== 8'd100) begin
      errors++;
      $display("FAIL release_setup: state=%0d level=%0d, need 1/100", EnvState, Level);
    end
    Gate = 1'b0;
    tick();
    checks++;
    if (EnvState !== 3'd4 || Level !== 8'd100) begin
      errors++;
      $display("FAIL release_enter: state=%0d level=%0d, need 4/100", EnvState, Level);
    end
    for (int t = 1; t <= 200; t++) begin
      tick();
      checks++;
      if (EnvState !== 3'd4 || Level !== 8'(100 - t / 2)) begin
        errors++;
        $display("FAIL release_ramp t=%0d: state=%0d level=%0d, need 4/%0d", t, EnvState, Level, 100 - t / 2);
      end
    end
    tick();
    checks++;
    if (EnvState !== 3'd0 || Level !== 8'd0) begin
      errors++;
      $display("FAIL release_to_idle: state=%0d level=%0d, need 0/0", EnvState, Level);
    end
  endtask

  task automatic test_retrigger();
    logic [7:0] exp_level;
`ifdef ENV_LEGATO_RETRIGGER_EN
    exp_level = 8'd60;
`else
    exp_level = 8'd0;
`endif
    do_reset();
    Attack = 8'd0; Decay = 8'd0; Release = 8'd7; Sustain = 8'd0;
    Gate = 1'b1;
    repeat (61) tick();
    Gate = 1'b0;
    tick();
    checks++;
    if (EnvState !== 3'd4 || Level !== 8'd60) begin
      errors++;
      $display("FAIL retrig_setup: state=%0d level=%0d, need 4/60", EnvState, Level);
    end
    Gate = 1'b1;
    tick();
    checks++;
    if (EnvState !== 3'd1 || Level !== exp_level) begin
      errors++;
      $display("FAIL retrig_edge: state=%0d level=%0d, need 1/%0d", EnvState, Level, exp_level);
    end
    tick();
    checks++;
    if (EnvState !== 3'd1 || Level !== exp_level + 8'd1) begin
      errors++;
      $display("FAIL retrig_continue: state=%0d level=%0d, need 1/%0d", EnvState, Level, exp_level + 8'd1);
    end
  endtask

  task automatic test_vca_out();
    Waveform = 8'd0;
    run_to_sustain();
    checks++;
    if (EnvState !== 3'd3 || Level !== 8'd128 || Out !== 8'd0) begin
      errors++;
      $display("FAIL vca_setup: state=%0d level=%0d out=%0d, need 3/128/0", EnvState, Level, Out);
    end
    Waveform = 8'd200;
    #1;
    checks++;
    if (Out !== 8'd0) begin
      errors++;
      $display("FAIL vca_no_comb_path: out=%0d, need 0", Out);
    end
    tick();
    checks++;
    if (Out !== 8'd100) begin
      errors++;
      $display("FAIL vca_200x128: out=%0d, need 100", Out);
    end
    Sustain = 8'd255;
    tick();
    checks++;
    if (Level !== 8'd255 || Out !== 8'd100) begin
      errors++;
      $display("FAIL vca_level_load: level=%0d out=%0d, need 255/100", Level, Out);
    end
    Waveform = 8'd255;
    tick();
    checks++;
    if (Out !== 8'd254) begin
      errors++;
      $display("FAIL vca_full_scale: out=%0d, need 254", Out);
    end
  endtask

  task automatic test_reset_mid_note();
    Waveform = 8'd255;
    run_to_sustain();
    tick();
    checks++;
    if (EnvState !== 3'd3 || Out !== 8'd127) begin
      errors++;
      $display("FAIL midreset_setup: state=%0d out=%0d, need 3/127", EnvState, Out);
    end
    Reset = 1'b1;
    #1;
    checks++;
    if (EnvState !== 3'd0 || Level !== 8'd0 || Out !== 8'd0) begin
      errors++;
      $display("FAIL midreset_immediate: state=%0d level=%0d out=%0d, need 0/0/0", EnvState, Level, Out);
    end
    tick();
    Reset = 1'b0;
    #1;
    checks++;
    if (EnvState !== 3'd0 || Level !== 8'd0 || Out !== 8'd0) begin
      errors++;
      $display("FAIL midreset_held: state=%0d level=%0d out=%0d, need 0/0/0", EnvState, Level, Out);
    end
    tick();
    checks++;
    if (EnvState !== 3'd1 || Level !== 8'd0 || Out !== 8'd0) begin
      errors++;
      $display("FAIL midreset_attack: state=%0d level=%0d out=%0d, need 1/0/0", EnvState, Level, Out);
    end
    tick();
    checks++;
    if (EnvState !== 3'd1 || Level !== 8'd1) begin
      errors++;
      $display("FAIL midreset_ramp: state=%0d level=%0d, need 1/1", EnvState, Level);
    end
  endtask

  task automatic test_back_to_back();
    // Gate drop exactly at the attack ceiling goes to Release, not Decay.
    do_reset();
    Attack = 8'd0; Decay = 8'd0; Release = 8'd0; Sustain = 8'd0;
    Gate = 1'b1;
    repeat (256) tick();
    Gate = 1'b0;
    tick();
    checks++;
    if (EnvState !== 3'd4 || Level !== 8'd255) begin
      errors++;
      $display("FAIL drop_at_max: state=%0d level=%0d, need 4/255", EnvState, Level);
    end
    // One-clock note: Release entered at level 0 drops to Idle next clock.
    do_reset();
    Gate = 1'b1;
    tick();
    Gate = 1'b0;
    tick();
    checks++;
    if (EnvState !== 3'd4 || Level !== 8'd0) begin
      errors++;
      $display("FAIL short_note_release: state=%0d level=%0d, need 4/0", EnvState, Level);
    end
    tick();
    checks++;
    if (EnvState !== 3'd0 || Level !== 8'd0) begin
      errors++;
      $display("FAIL short_note_idle: state=%0d level=%0d, need 0/0", EnvState, Level);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_attack_decay_sustain();
    test_attack_rate();
    test_release();
    test_retrigger();
    test_vca_out();
    test_reset_mid_note();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/envelope_vca.md
ENVELOPE_VCA -- requirements
Module: envelope_vca

Interface
REQ-001 The block SHALL have parameter WAVE_DEPTH, default 8, meaning the bit width of the unsigned input and output samples.
REQ-002 The block SHALL have parameter ENV_DEPTH, default 8, meaning the bit width of the envelope level and all rate and level controls.
REQ-003 Port Clock, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-004 Port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port Gate, input, 1 bit: note on while high.
REQ-006 Port Attack, Decay and Release, inputs, ENV_DEPTH bits each: clocks per level step, minus 1.
REQ-007 Port Sustain, input, ENV_DEPTH bits: sustain level.
REQ-008 Port Waveform, input, WAVE_DEPTH bits: unsigned sample from the upstream wave generator.
REQ-009 Port Out, output, WAVE_DEPTH bits: amplitude-scaled sample.
REQ-010 Port Level, output, ENV_DEPTH bits: current envelope level.
REQ-011 Port EnvState, output, 3 bits: Idle=0, Attack=1, Decay=2, Sustain=3, Release=4.

Function
REQ-012 GatePrev SHALL register Gate; a rising edge is Gate=1 and GatePrev=0.
REQ-013 A rising edge in any state SHALL enter Attack and clear RateCnt to 0.
REQ-014 Stepping SHALL work as follows in Attack, Decay and Release: if RateCnt equals the active rate, RateCnt goes to 0 and Level steps by 1; otherwise RateCnt increments.
REQ-015 Attack SHALL work as follows: Level counts up; at Level = ENV_MAX (all ones), the next clock enters Decay and clears RateCnt, and Level never wraps.
REQ-016 Decay SHALL work as follows: when Level <= Sustain, the next clock enters Sustain; otherwise Level counts down.
REQ-017 Sustain SHALL work as follows: Level is loaded from Sustain every clock, so live Sustain changes are tracked.
REQ-018 Gate=0 in Attack, Decay or Sustain SHALL enter Release on the next clock and clear RateCnt.
REQ-019 Release SHALL work as follows: Level counts down; when Level = 0, the next clock enters Idle; Release entered with Level=0 goes to Idle one clock later.
REQ-020 Idle SHALL hold Level = 0.
REQ-021 A rising edge SHALL take priority over every other transition in the same clock.
REQ-022 Out SHALL be registered as the upper WAVE_DEPTH bits of Waveform*Level, a (WAVE_DEPTH+ENV_DEPTH)-bit product, using the Level register value.
REQ-023 Out SHALL have exactly 1 clock of latency from Waveform.
REQ-024 Full-scale Out SHALL be 254 for 8/8 widths; this truncation is intended.

Reset
REQ-025 Reset asserted SHALL immediately force: EnvState=Idle, Level=0, RateCnt=0, Out=0 and GatePrev=0.
REQ-026 Reset mid-note SHALL abort the envelope with no release tail.
REQ-027 If Gate is high at reset release, the first clock SHALL detect a rising edge and enter Attack.

Configuration
REQ-028 Macro ENV_LEGATO_RETRIGGER_EN SHALL control retrigger behaviour.
REQ-029 With ENV_LEGATO_RETRIGGER_EN defined, a rising edge SHALL keep the current Level and Attack SHALL continue upward from it.
REQ-030 Without ENV_LEGATO_RETRIGGER_EN, a rising edge SHALL clear Level to 0 in the same clock it enters Attack.

Structure
REQ-031 Shared package synth_pkg SHALL hold the EnvState encoding constants and ENV_MAX.
REQ-032 Sub-module env_rate_counter SHALL implement RateCnt compare/clear and emit a one-clock Step pulse; its inputs are Clock, Reset, Clear and Rate.
REQ-033 envelope_vca SHALL instantiate env_rate_counter once, selecting the rate by state.

Verification
REQ-034 Attack=0, Decay=0, Sustain=128, Gate rising: the bench SHALL see EnvState=1, Level hitting 255 after 255 clocks, then Decay, then Sustain with Level=128.
REQ-035 Attack=3: the bench SHALL see Level increment exactly every 4 clocks in Attack.
REQ-036 Gate drop at Level=100 during Attack, Release=1: the bench SHALL see Release, Level decrementing every 2 clocks, Idle reached 1 clock after Level=0.
REQ-037 Retrigger at Level=60 in Release: the bench SHALL see Level=0 without the macro and Level continuing from 60 with ENV_LEGATO_RETRIGGER_EN.
REQ-038 Waveform=200, Level=128: the bench SHALL see Out=100 one clock later; Waveform=255 at Level=255 SHALL give Out=254.
REQ-039 Reset pulsed in Sustain with Gate held high: the bench SHALL see all outputs 0 immediately, then Attack on the first clock after deassertion.
